inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache between the IF stage's fetch port (`inst_ren`/`inst_addr`/`inst_data`) and the external instruction memory. Hits return the word combinationally in the same cycle, so IF latches it at the next edge exactly as with a flat ROM. Misses raise `inst_stall`, which the pipeline controller uses to drop `if_en` and reset `id` while the cache refills a whole line over a word-wise req/ack handshake.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per line; a power of two, at least 2.
- `LINES`, 64: number of lines; a power of two.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_ren`  in  1  fetch request from IF.
- `inst_addr`  in  32  fetch byte address; bits [1:0] are ignored.
- `inst_data`  out  32  fetched word; valid when `inst_ren` is 1 and `inst_stall` is 0.
- `inst_stall`  out  1  miss in progress; IF must hold `inst_addr`.
- `flush`  in  1  one-cycle pulse that invalidates every line.
- `mem_req`  out  1  refill word request.
- `mem_addr`  out  32  word-aligned refill address.
- `mem_ack`  in  1  memory has placed the word on `mem_rdata`, sampled this cycle.
- `mem_rdata`  in  32  refill data.

## Operation
- Address split: offset = `inst_addr[OFF+1:2]` with OFF = log2(LINE_WORDS); index = the next log2(LINES) bits; tag = the remaining upper bits.
- Storage: tag array, valid bit per line, and a data array of LINES×LINE_WORDS words.
- The FSM has three states: IDLE, REFILL, RESUME.
- IDLE:
  - `inst_ren`=0: `inst_stall`=0, `inst_data`=0, no lookup.
  - `inst_ren`=1 and the line is valid with a matching tag: hit. `inst_stall`=0 and `inst_data` = the stored word, combinationally.
  - Miss: `inst_stall`=1 in the same cycle. Latch `miss_tag` and `miss_index`, set `word_cnt`=0, go to REFILL.
- REFILL:
  - `mem_req`=1 and `mem_addr` = {miss_tag, miss_index, word_cnt, 2'b00}. Both stay stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` into data[miss_index][word_cnt], then increment `word_cnt`.
  - On the ack for word LINE_WORDS-1: write the tag, set valid unless a flush occurred during the refill, drop `mem_req`, go to RESUME.
  - `mem_req` is low for at least the cycle after each ack. Each word is a fresh request.
- RESUME: `inst_stall`=1 for one cycle, then return to IDLE, where the lookup repeats with the current `inst_addr`.
  - If `inst_addr` changed during the stall (for example an IF reset to 0), the new address is simply looked up again.
- Flush:
  - In IDLE or RESUME: clear all valid bits at the edge. A fetch in the same cycle as the flush still sees the pre-flush array.
  - In REFILL: clear all valid bits and set `flush_pend`. The refill runs to completion, but the line is not marked valid, so it misses again.
- Reset: valid bits cleared, state IDLE, `word_cnt`=0, `flush_pend`=0.
  - Output reset values: `inst_stall`=0, `mem_req`=0, `mem_addr`=0, `inst_data`=0.
  - An outstanding request is abandoned. The memory side must tolerate `mem_req` dropping without an ack.

## Timing
- Hit latency: 0 cycles (combinational `inst_data`).
- Miss penalty, with memory acking k cycles after each request is raised: 1 + LINE_WORDS×(k+2) cycles of `inst_stall` before the hit cycle.
  - Example: k=0, LINE_WORDS=4 gives 9 stall cycles.
- `mem_ack` outside REFILL is ignored.
- `word_cnt` is OFF bits wide and wraps to 0 at line completion.

## Configuration
- `ICACHE_STAT_EN` defined:
  - Adds outputs `hit_cnt` (32) and `miss_cnt` (32), both reset to 0.
  - `hit_cnt` increments on each IDLE hit cycle with `inst_ren`=1; `miss_cnt` increments on each IDLE→REFILL transition.
  - Both wrap at 2^32 and are unaffected by `flush`.
- `ICACHE_STAT_EN` undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package `icache_pkg` holds:
  - the state enum, with IDLE=2'd0, REFILL=2'd1, RESUME=2'd2;
  - the localparams OFF, IDX and TAG widths derived from the parameters;
  - the address-split helper functions.
- Sub-module `icache_data_ram`: LINES×LINE_WORDS×32 array with asynchronous read and a single synchronous write port, so it can later be swapped for distributed RAM. Tag and valid storage stay in the top level.

## Test plan
1. After reset, fetch 0x0000_0040; memory acks each request 1 cycle later with 0x2000_0010..0x2000_0013 → `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C; `inst_stall` high for 13 cycles; then `inst_data`=0x2000_0010.
2. After test 1, fetch 0x44, 0x48, 0x4C back-to-back → `inst_data` = 0x2000_0011, 0x2000_0012, 0x2000_0013 with `inst_stall`=0 and `mem_req`=0 throughout.
3. Fetch 0x0000_1040 (same index as 0x40, different tag) → miss and refill from 0x1040; a later fetch of 0x40 misses again.
4. Pulse `flush` during the second refill word of a miss on 0x80 → the refill completes, the re-lookup misses, and a second refill of 0x80 is issued.
5. Drive `rst` low during REFILL → `mem_req` and `inst_stall` drop asynchronously; after release, fetching 0x40 misses.
6. With `ICACHE_STAT_EN`: run tests 1–2 → `hit_cnt`=4, `miss_cnt`=1.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  localparam int LINE_WORDS_DEF = 4;
  localparam int LINES_DEF      = 64;
  localparam int OFF = $clog2(LINE_WORDS_DEF);
  localparam int IDX = $clog2(LINES_DEF);
  localparam int TAG = 30 - OFF - IDX;

  function automatic logic [31:0] field_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int off_w);
    return (a >> 2) & field_mask(off_w);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
    return (a >> (2 + off_w)) & field_mask(idx_w);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
    return a >> (2 + off_w + idx_w);
  endfunction

  // Rebuilds a word-aligned byte address from its tag/index/offset fields.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx,
                                            input logic [31:0] off, input int off_w,
                                            input int idx_w);
    return (tag << (2 + off_w + idx_w)) | (idx << (2 + off_w)) | (off << 2);
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-port and refill-port bundle of the instruction cache.
interface inst_cache_if;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_ren, inst_addr, flush, mem_ack, mem_rdata,
    output inst_data, inst_stall, mem_req, mem_addr
  );

  modport master (
    output inst_ren, inst_addr, flush, mem_ack, mem_rdata,
    input  inst_data, inst_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_ram.sv
// Cache data array: asynchronous read, one synchronous write port (distributed-RAM friendly).
module icache_data_ram #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                                    clk,
  input  logic                                    we,
  input  logic [$clog2(LINES*LINE_WORDS)-1:0]     waddr,
  input  logic [31:0]                             wdata,
  input  logic [$clog2(LINES*LINE_WORDS)-1:0]     raddr,
  output logic [31:0]                             rdata
);

  logic [31:0] mem [LINES*LINE_WORDS];

  // NOTE: storage arrays take no reset; the valid bits in the top level decide what is readable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-wise line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STAT_EN.
module inst_cache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic          clk,
  input  logic          rst,
  inst_cache_if.slave   bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_REFILL = ST_REFILL;
  localparam logic [1:0] S_RESUME = ST_RESUME;

  logic [1:0]       state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;
  logic [OFF_W-1:0] word_cnt;
  logic             flush_pend;
  logic             ack_gap;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [31:0]      ram_rdata;
  logic             lookup, hit, miss, ack_take, last_word;

  assign req_tag = TAG_W'(addr_tag(bus.inst_addr, OFF_W, IDX_W));
  assign req_idx = IDX_W'(addr_idx(bus.inst_addr, OFF_W, IDX_W));
  assign req_off = OFF_W'(addr_off(bus.inst_addr, OFF_W));

  // Outputs are qualified with rst so they read as idle while reset is held.
  assign lookup    = rst && (state == S_IDLE) && bus.inst_ren;
  assign hit       = lookup && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign miss      = lookup && !hit;
  assign ack_take  = (state == S_REFILL) && !ack_gap && bus.mem_ack;
  assign last_word = (word_cnt == OFF_W'(LINE_WORDS - 1));

  assign bus.inst_stall = miss || (rst && (state != S_IDLE));
  assign bus.inst_data  = hit ? ram_rdata : 32'd0;
  assign bus.mem_req    = rst && (state == S_REFILL) && !ack_gap;
  assign bus.mem_addr   = (rst && (state == S_REFILL))
                        ? line_addr(32'(miss_tag), 32'(miss_index), 32'(word_cnt), OFF_W, IDX_W)
                        : 32'd0;

  icache_data_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .clk   (clk),
    .we    (ack_take),
    .waddr ({miss_index, word_cnt}),
    .wdata (bus.mem_rdata),
    .raddr ({req_idx, req_off}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
      word_cnt   <= '0;
      flush_pend <= 1'b0;
      ack_gap    <= 1'b0;
    end else begin
      ack_gap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss) begin
            state      <= S_REFILL;
            miss_tag   <= req_tag;
            miss_index <= req_idx;
            word_cnt   <= '0;
          end
        end
        S_REFILL: begin
          if (ack_take) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
              state      <= S_RESUME;
              flush_pend <= 1'b0;
            end else begin
              ack_gap <= 1'b1;
            end
          end
        end
        S_RESUME: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      // A flush during refill lets the line fill but keeps it invalid.
      if (bus.flush) begin
        valid <= '0;
        if ((state == S_REFILL) && !(ack_take && last_word)) flush_pend <= 1'b1;
      end else if (ack_take && last_word && !flush_pend) begin
        valid[miss_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ack_take && last_word) tag_mem[miss_index] <= miss_tag;
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: a line-level cache model predicts refills, stall length and data.
module tb_inst_cache;

  localparam int LW = 4;
  localparam int NL = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_cache_if bus ();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  inst_cache #(
    .LINE_WORDS (LW),
    .LINES      (NL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference model: which memory line each cache slot holds.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + a / 4;
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % NL);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LW * NL);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[slot_of(a)] && (m_tag[slot_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  logic [31:0] exp_data  [$];
  logic [31:0] exp_maddr [$];
  int fixed_k  = -1;
  int k_sum    = 0;
  int req_seen = 0;

  // Memory responder: checks each request address and acks k cycles later.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst && bus.mem_req) begin
        int k;
        logic [31:0] a;
        a = bus.mem_addr;
        req_seen++;
        if (exp_maddr.size() == 0) fail_now($sformatf("unexpected mem_req addr=%h", a));
        else check("mem_addr", a, exp_maddr.pop_front());
        k = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 2));
        k_sum += k;
        for (int i = 0; i < k; i++) begin
          @(negedge clk);
          if (rst) begin
            check("mem_req held", {31'd0, bus.mem_req}, 32'd1);
            check("mem_addr held", bus.mem_addr, a);
          end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(a);
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
      end
    end
  end

  // Fetch monitor: every delivered word is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.inst_ren && !bus.inst_stall) begin
        if (exp_data.size() == 0) fail_now($sformatf("unexpected inst_data %h", bus.inst_data));
        else check("inst_data", bus.inst_data, exp_data.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int flush_word, input bit flush_now,
                       output int stalls);
    int idx, refills, base;
    logic [31:0] tg, lb;
    bit hit, flushed, done;
    idx = slot_of(a);
    tg  = tag_of(a);
    lb  = a - (a % (4 * LW));
    hit = model_hit(a);
    refills = hit ? 0 : ((flush_word >= 0) ? 2 : 1);
    for (int r = 0; r < refills; r++)
      for (int w = 0; w < LW; w++) exp_maddr.push_back(lb + 32'(4 * w));
    exp_data.push_back(mem_word(a));
    k_sum = 0; base = req_seen; flushed = 0; done = 0; stalls = 0;
    bus.inst_ren  = 1'b1;
    bus.inst_addr = a;
    if (flush_now) bus.flush = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!flush_now) bus.flush = 1'b0;
      if (!hit && flush_word >= 0 && !flushed && req_seen >= base + flush_word + 1) begin
        bus.flush = 1'b1;
        flushed   = 1'b1;
      end
      if (!bus.inst_stall) begin
        done = 1;
        break;
      end
      stalls++;
    end
    if (!done) fail_now($sformatf("fetch timeout addr=%h", a));
    check($sformatf("stall cycles @%h", a), 32'(stalls), 32'(refills * (1 + 2 * LW) + k_sum));
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    if (flushed) model_clear();
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    if (flush_now) model_clear();
  endtask

  task automatic flush_idle();
    bus.inst_ren = 1'b0;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bit seen;
    logic [31:0] a;
    model_clear();
    bus.flush     = 1'b0;
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    check("reset inst_stall", {31'd0, bus.inst_stall}, 32'd0);
    check("reset mem_req",    {31'd0, bus.mem_req},    32'd0);
    check("reset mem_addr",   bus.mem_addr,            32'd0);
    check("reset inst_data",  bus.inst_data,           32'd0);
    bus.inst_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: cold miss with k=1 -> 13 stall cycles
    fixed_k = 1;
    fetch(32'h40, -1, 0, st);
    check("test1 stall count", 32'(st), 32'd13);
    // Test 2: back-to-back hits on the same line
    fetch(32'h44, -1, 0, st);
    fetch(32'h48, -1, 0, st);
    fetch(32'h4C, -1, 0, st);
`ifdef ICACHE_STAT_EN
    check("hit_cnt",  hit_cnt,  32'd4);
    check("miss_cnt", miss_cnt, 32'd1);
`endif
    fixed_k = -1;
    // Test 3: conflicting tag on the same index evicts the line
    fetch(32'h1040, -1, 0, st);
    fetch(32'h40, -1, 0, st);
    // Test 4: flush during the second refill word forces a second refill
    fetch(32'h80, 1, 0, st);
    fetch(32'h84, -1, 0, st);

    // Test 5: reset during refill
    flush_idle();
    exp_maddr.push_back(32'h40);
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h40;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("test5 no mem_req");
    #2;
    rst = 1'b0;
    #1;
    check("async rst mem_req",    {31'd0, bus.mem_req},    32'd0);
    check("async rst inst_stall", {31'd0, bus.inst_stall}, 32'd0);
    check("async rst mem_addr",   bus.mem_addr,            32'd0);
    model_clear();
    bus.inst_ren = 1'b0;
    repeat (4) @(posedge clk);
    exp_maddr.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    fetch(32'h40, -1, 0, st);

    // Randomized traffic over a few conflicting tags and indices
    for (int i = 0; i < 150; i++) begin
      int r;
      a = 32'($urandom_range(0, 2)) * (4 * LW * NL) + 32'($urandom_range(0, 3)) * (4 * LW)
        + 32'($urandom_range(0, LW - 1)) * 4;
      r = int'($urandom_range(0, 9));
      if (r == 0) flush_idle();
      else if (r == 1) fetch(a, int'($urandom_range(0, LW - 1)), 0, st);
      else if (r == 2) begin
        bus.inst_ren = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else fetch(a, -1, (r == 3) && model_hit(a), st);
    end

    bus.inst_ren = 1'b0;
    repeat (4) @(posedge clk);
    check("exp_data drained",  32'(exp_data.size()),  32'd0);
    check("exp_maddr drained", 32'(exp_maddr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
